// File: rtl/lcd_access_arbiter.sv
`timescale 1ns/1ps
// lcd_access_arbiter
// Round-robin arbiter between two requesters sharing an LCD1602 controller.
// The granted requester's 4-bit value is latched into its own display field,
// the controller's ready input is strobed for READY_CYCLES cycles, and a
// hold-off of HOLD_CYCLES cycles lets the controller finish its write sequence.
//
// Ports:
//   clk          system clock
//   reset        asynchronous active-low reset
//   req0/req1    level requests, held until the matching ack
//   data0/data1  values for in1_o / in2_o, sampled on grant
//   ack0/ack1    one-cycle grant acknowledges
//   in1_o/in2_o  registered display fields
//   ready_o      strobe to the LCD controller ready_i
//   busy_o       high whenever the arbiter is not idle
//   last_grant   index of the most recently granted requester
module lcd_access_arbiter #(
    parameter int unsigned READY_CYCLES = 4,
    parameter int unsigned HOLD_CYCLES  = 2_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req0,
    input  logic [3:0] data0,
    output logic       ack0,
    input  logic       req1,
    input  logic [3:0] data1,
    output logic       ack1,
    output logic [3:0] in1_o,
    output logic [3:0] in2_o,
    output logic       ready_o,
    output logic       busy_o,
    output logic       last_grant
);

    localparam int unsigned MAX_CYCLES = (READY_CYCLES > HOLD_CYCLES) ? READY_CYCLES : HOLD_CYCLES;
    localparam int unsigned CNT_W      = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STROBE = 2'd1,
        HOLD   = 2'd2
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic               grant_idx;

    // On a tie the requester that was not served last wins; otherwise whoever asks.
    assign grant_idx = (req0 && req1) ? ~last_grant : req1;

    // Arbiter FSM with shared strobe/hold down-counter; all outputs registered.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            cnt        <= '0;
            ready_o    <= 1'b0;
            ack0       <= 1'b0;
            ack1       <= 1'b0;
            in1_o      <= 4'h0;
            in2_o      <= 4'h0;
            last_grant <= 1'b1;
            busy_o     <= 1'b0;
        end else begin
            ack0 <= 1'b0;
            ack1 <= 1'b0;
            case (state)
                IDLE: begin
                    if (req0 || req1) begin
                        if (grant_idx) begin
                            ack1  <= 1'b1;
                            in2_o <= data1;
                        end else begin
                            ack0  <= 1'b1;
                            in1_o <= data0;
                        end
                        last_grant <= grant_idx;
                        ready_o    <= 1'b1;
                        busy_o     <= 1'b1;
                        cnt        <= CNT_W'(READY_CYCLES - 1);
                        state      <= STROBE;
                    end
                end
                STROBE: begin
                    if (cnt == '0) begin
                        ready_o <= 1'b0;
                        cnt     <= CNT_W'(HOLD_CYCLES - 1);
                        state   <= HOLD;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                HOLD: begin
                    if (cnt == '0) begin
                        busy_o <= 1'b0;
                        state  <= IDLE;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                default: begin
                    ready_o <= 1'b0;
                    busy_o  <= 1'b0;
                    cnt     <= '0;
                    state   <= IDLE;
                end
            endcase
        end
    end

endmodule
